// File: rtl/free_list_pkg.sv
// Shared rename/ROB package: register-file sizing and the free-list
// request/response packet types used between rename and the ROB.
package free_list_pkg;

  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int NUM_FL   = NUM_PR - NUM_ARCH;

  localparam int FL_TAG_W = $clog2(NUM_PR);
  localparam int FL_PTR_W = $clog2(NUM_FL);
  localparam int FL_CNT_W = FL_PTR_W + 1;

  typedef struct packed {
    logic                dispatch;
    logic                retire;
    logic [FL_TAG_W-1:0] T_old_in;
  } FREE_LIST_PACKET_IN;

  typedef struct packed {
    logic [FL_TAG_W-1:0] T_out;
    logic                T_valid;
    logic                struct_hazard;
    logic [FL_CNT_W-1:0] free_count;
  } FREE_LIST_PACKET_OUT;

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular buffer of free tags. Rename pops the
// tag at head, retire pushes the released tag at tail. No same-cycle bypass:
// a tag pushed into an empty list becomes allocatable one cycle later.
module free_list
  import free_list_pkg::*;
#(
  parameter int NUM_PR   = free_list_pkg::NUM_PR,
  parameter int NUM_ARCH = free_list_pkg::NUM_ARCH,
  parameter int NUM_FL   = NUM_PR - NUM_ARCH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       dispatch,
  input  logic                       retire,
  input  logic [$clog2(NUM_PR)-1:0]  T_old_in,
  output logic [$clog2(NUM_PR)-1:0]  T_out,
  output logic                       T_valid,
  output logic                       struct_hazard,
  output logic [$clog2(NUM_FL):0]    free_count,
  output logic                       overflow
);

  localparam int TAG_W = $clog2(NUM_PR);
  localparam int PTR_W = $clog2(NUM_FL);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] entry_r      [NUM_FL];
  logic [TAG_W-1:0] entry_next_s [NUM_FL];
  logic [PTR_W-1:0] head_r, head_next_s;
  logic [PTR_W-1:0] tail_r, tail_next_s;
  logic [CNT_W-1:0] count_r, count_next_s;
  logic             overflow_r, overflow_next_s;

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;

  // Next-state for the buffer (reset has priority) and outputs from current state.
  always_comb begin
    entry_next_s    = entry_r;
    head_next_s     = head_r;
    tail_next_s     = tail_r;
    count_next_s    = count_r;
    overflow_next_s = overflow_r;

    empty_s = (count_r == {CNT_W{1'b0}});
    full_s  = (count_r == CNT_W'(NUM_FL));
    // Both qualifiers look only at registered count, so a push into an
    // empty list never satisfies a pop in the same cycle.
    pop_s   = en & dispatch & ~empty_s;
    push_s  = en & retire & ~full_s;

    if (reset) begin
      for (int i = 0; i < NUM_FL; i++) begin
        entry_next_s[i] = TAG_W'(NUM_ARCH + i);
      end
      head_next_s     = {PTR_W{1'b0}};
      tail_next_s     = {PTR_W{1'b0}};
      count_next_s    = CNT_W'(NUM_FL);
      overflow_next_s = 1'b0;
    end else begin
      if (push_s) begin
        entry_next_s[tail_r] = T_old_in;
        tail_next_s          = tail_r + PTR_W'(1);
      end else begin
        tail_next_s = tail_r;
      end

      if (pop_s) begin
        head_next_s = head_r + PTR_W'(1);
      end else begin
        head_next_s = head_r;
      end

      count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

      // A retire that finds the list full is lost; remember it until reset.
      if (en & retire & full_s) begin
        overflow_next_s = 1'b1;
      end else begin
        overflow_next_s = overflow_r;
      end
    end

    T_out         = entry_r[head_r];
    T_valid       = ~empty_s;
    struct_hazard = empty_s;
    free_count    = count_r;
    overflow      = overflow_r;
  end

  // State register: all updates, including reset, arrive via next-state.
  always_ff @(posedge clock) begin
    entry_r    <= entry_next_s;
    head_r     <= head_next_s;
    tail_r     <= tail_next_s;
    count_r    <= count_next_s;
    overflow_r <= overflow_next_s;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 The block SHALL take parameter NUM_PR, default 64, as the physical register count.
REQ-002 The block SHALL take parameter NUM_ARCH, default 32, as the architectural register count.
REQ-003 The block SHALL take parameter NUM_FL, default NUM_PR-NUM_ARCH (32), as the free-list capacity.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  global stage enable; when 0, no push and no pop occurs.
REQ-007 dispatch  input  1  rename requests one free physical register this cycle (pop).
REQ-008 retire  input  1  ROB head retires; T_old_in is returned to the list (push).
REQ-009 T_old_in  input  $clog2(NUM_PR)  physical register being freed at retire.
REQ-010 T_out  output  $clog2(NUM_PR)  physical register offered to rename; equals entry[head].
REQ-011 T_valid  output  1  T_out is allocatable, i.e. count != 0.
REQ-012 struct_hazard  output  1  list empty (count == 0); rename must stall.
REQ-013 free_count  output  $clog2(NUM_FL)+1  number of valid entries.
REQ-014 overflow  output  1  sticky error flag: a push was attempted while full.

Function
REQ-015 State SHALL be a circular buffer: entry[NUM_FL], head and tail pointers of $clog2(NUM_FL) bits, and count of $clog2(NUM_FL)+1 bits.
REQ-016 Pointers SHALL wrap modulo NUM_FL; NUM_FL is a power of two, so wrap is natural overflow.
REQ-017 pop = en & dispatch & (count != 0); a pop SHALL advance head by 1 at the next edge.
REQ-018 push = en & retire & (count != NUM_FL); a push SHALL write T_old_in to entry[tail] and advance tail by 1 at the next edge.
REQ-019 count_next SHALL be count + push - pop; a simultaneous push and pop leaves count unchanged.
REQ-020 T_out, T_valid, struct_hazard and free_count SHALL be combinational from registered state only, with zero-cycle latency to the requester.
REQ-021 There SHALL be no same-cycle bypass: when count == 0, a dispatch is refused even if a push occurs that cycle, and the pushed register becomes visible on the next cycle.
REQ-022 Push while full (count == NUM_FL) SHALL be dropped without changing state and SHALL set overflow, which stays 1 until reset.
REQ-023 Dispatch while empty SHALL have no state effect; struct_hazard = 1 signals the stall.
REQ-024 When en = 0, all state SHALL hold, regardless of dispatch and retire.
REQ-025 Entries outside [head, tail) are don't-care and SHALL NOT affect outputs.

Reset
REQ-026 On reset, entry[i] SHALL be NUM_ARCH+i for i = 0..NUM_FL-1 (registers 32..63).
REQ-027 On reset, head = 0, tail = 0, count = NUM_FL, and overflow = 0.
REQ-028 Reset values of outputs SHALL be T_out = NUM_ARCH (32), T_valid = 1, struct_hazard = 0, free_count = NUM_FL.
REQ-029 Reset SHALL take priority over en, dispatch and retire in the same cycle.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight contents and restore the REQ-026/027 state at the next edge.

Structure
REQ-031 NUM_PR, NUM_ARCH, NUM_FL and the packet structs FREE_LIST_PACKET_IN (dispatch, retire, T_old_in) and FREE_LIST_PACKET_OUT (T_out, T_valid, struct_hazard, free_count) SHALL live in the shared package used by the ROB.
REQ-032 The block SHALL be a single module with no sub-modules; one always_ff holds state and one always_comb holds next-state and output logic.
REQ-033 T_old_in SHALL connect directly to the ROB T_old_out at the retire head, and T_out SHALL feed the ROB T_in at dispatch.

Verification
REQ-034 Reset then 32 consecutive dispatches with en = 1 -> T_out sequence 32, 33, ..., 63; after the last, free_count = 0, struct_hazard = 1, T_valid = 0.
REQ-035 From empty, one cycle of retire with T_old_in = 5 and dispatch = 1 -> no pop that cycle; next cycle T_out = 5, free_count = 1.
REQ-036 After 3 pops, simultaneous dispatch and retire with T_old_in = 7 -> free_count stays 29, head and tail each advance by 1, and 7 appears 29 pops later.
REQ-037 Right after reset (full), retire with T_old_in = 9 -> overflow = 1 and stays 1, free_count stays 32, T_out stays 32.
REQ-038 Wrap-around: pop 32, push 32 values 0..31, pop 32 -> T_out sequence 0..31 in order; pointers wrap to 0 with no glitch.
REQ-039 Reset asserted after 10 pops with en = 0 and dispatch = 1 -> next cycle head = 0, free_count = 32, T_out = 32, overflow = 0.
